// File: rtl/radix2_divider.sv
// Sequential restoring divider: one quotient bit per clock, N+1 cycles from accept to result.
// Signed operation divides magnitudes and then applies the signs, so truncation is toward zero.
module radix2_divider #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         is_signed,
    input  logic [N-1:0] divident,
    input  logic [N-1:0] divider,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] reminder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MIN_PAT = {1'b1, {(N-1){1'b0}}};

    // Handshakes: a word moves on a rising edge where valid && ready; the producer
    // holds valid and data steady until that edge, and ready never depends on valid.
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, b_q, rem_q, q_q;
    logic [CW-1:0]  cnt_q;
    logic           sign_q_q, sign_r_q, zero_q, ovf_q;
    logic           accept, last_iter;
    logic [N-1:0]   a_abs, b_abs, diff;
    logic [N:0]     partial;
    logic           ge;

    assign last_iter = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: if (last_iter) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // |MIN| negates to itself, which is exactly 2^(N-1) read as unsigned.
    assign a_abs = (is_signed && divident[N-1]) ? -divident : divident;
    assign b_abs = (is_signed && divider[N-1])  ? -divider  : divider;

    // The difference only matters when it is non-negative, where it always fits in N bits.
    assign partial = {rem_q, a_q[N-1]};
    assign ge      = (partial >= {1'b0, b_q});
    assign diff    = partial[N-1:0] - b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            quotient    <= '0;
            reminder    <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    a_q      <= a_abs;
                    b_q      <= b_abs;
                    rem_q    <= '0;
                    q_q      <= '0;
                    cnt_q    <= '0;
                    sign_q_q <= is_signed && (divident[N-1] != divider[N-1]);
                    sign_r_q <= is_signed && divident[N-1];
                    zero_q   <= (divider == '0);
                    ovf_q    <= is_signed && (divident == MIN_PAT) && (divider == '1);
                end
                CALC: begin
                    a_q   <= {a_q[N-2:0], 1'b0};
                    rem_q <= ge ? diff : partial[N-1:0];
                    q_q   <= {q_q[N-2:0], ge};
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: begin
                    // A zero divisor leaves rem = |dividend|, so re-signing it restores the raw dividend.
                    quotient    <= zero_q ? '1 : (sign_q_q ? -q_q : q_q);
                    reminder    <= sign_r_q ? -rem_q : rem_q;
                    div_by_zero <= zero_q;
                    overflow    <= ovf_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_radix2_divider.sv
// Bench for radix2_divider: vector table over N=32 and N=8 instances, random unsigned
// operands, back-pressure with back-to-back accept, and reset in the middle of an operation.
module tb_radix2_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid_32 = 1'b0, in_ready_32, is_signed_32 = 1'b0;
    logic [31:0] divident_32 = '0, divider_32 = '0, quotient_32, reminder_32;
    logic        out_valid_32, out_ready_32 = 1'b0, div_by_zero_32, overflow_32;

    logic        in_valid_8 = 1'b0, in_ready_8, is_signed_8 = 1'b0;
    logic [7:0]  divident_8 = '0, divider_8 = '0, quotient_8, reminder_8;
    logic        out_valid_8, out_ready_8 = 1'b0, div_by_zero_8, overflow_8;

    radix2_divider #(.N(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_32), .in_ready(in_ready_32),
        .is_signed(is_signed_32), .divident(divident_32), .divider(divider_32),
        .out_valid(out_valid_32), .out_ready(out_ready_32), .quotient(quotient_32),
        .reminder(reminder_32), .div_by_zero(div_by_zero_32), .overflow(overflow_32)
    );

    radix2_divider #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .is_signed(is_signed_8), .divident(divident_8), .divider(divider_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8), .quotient(quotient_8),
        .reminder(reminder_8), .div_by_zero(div_by_zero_8), .overflow(overflow_8)
    );

    // Selects which instance the driver tasks talk to.
    logic        sel8 = 1'b0;
    logic        obs_in_ready, obs_out_valid;
    logic [65:0] obs_res;

    always_comb begin
        if (sel8) begin
            obs_in_ready  = in_ready_8;
            obs_out_valid = out_valid_8;
            obs_res       = {24'b0, quotient_8, 24'b0, reminder_8, div_by_zero_8, overflow_8};
        end else begin
            obs_in_ready  = in_ready_32;
            obs_out_valid = out_valid_32;
            obs_res       = {quotient_32, reminder_32, div_by_zero_32, overflow_32};
        end
    end

    int checks = 0;
    int failures = 0;
    logic [65:0] exp_q[$];

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive_in(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (sel8) begin
            in_valid_8 = v; is_signed_8 = s; divident_8 = a[7:0]; divider_8 = b[7:0];
        end else begin
            in_valid_32 = v; is_signed_32 = s; divident_32 = a; divider_32 = b;
        end
    endtask

    task automatic set_out_ready(input logic v);
        out_ready_32 = v;
        out_ready_8  = v;
    endtask

    task automatic drive_junk();
        drive_in(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endtask

    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [65:0] expv);
        @(negedge clk);
        drive_in(1'b1, s, a, b);
        check("in_ready_idle", obs_in_ready, 1);
        @(posedge clk);
        exp_q.push_back(expv);
        #1;
        drive_junk();
        check("in_ready_after_accept", obs_in_ready, 0);
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_result();
        int lat = 0;
        int busy_ready = 0;
        while (!obs_out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (obs_in_ready) busy_ready++;
        end
        check("latency", lat, sel8 ? 9 : 33);
        check("in_ready_busy", busy_ready, 0);
    endtask

    task automatic collect();
        logic [65:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            @(negedge clk);
            set_out_ready(1'b1);
            check("result", obs_res, e);
            @(posedge clk);
            #1;
            set_out_ready(1'b0);
            check("after_transfer", {obs_out_valid, obs_in_ready}, 2'b01);
        end
    endtask

    typedef struct {
        logic        n8;
        logic        s;
        logic [31:0] a, b, q, r;
        logic        dz, ov;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [65:0] e;
        int bad;
        logic [31:0] ra, rb;

        vecs[0]  = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'd12345,      32'd123,        32'd100,        32'd45,         1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'h80,         32'hFF,         32'h80,         32'h00,         1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h80,         32'hFF,         32'h00,         32'h80,         1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 32'h7F,         32'h02,         32'h3F,         32'h01,         1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 32'h81,         32'h03,         32'hD6,         32'hFF,         1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 32'h00,         32'h00,         32'hFF,         32'h00,         1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0};

        // Reset state on both instances.
        repeat (3) @(posedge clk);
        #1;
        check("reset_32", {in_ready_32, out_valid_32, quotient_32, reminder_32, div_by_zero_32, overflow_32},
              {2'b10, 64'b0, 2'b00});
        check("reset_8", {in_ready_8, out_valid_8, quotient_8, reminder_8, div_by_zero_8, overflow_8},
              {2'b10, 16'b0, 2'b00});
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            sel8 = vecs[i].n8;
            start_op(vecs[i].s, vecs[i].a, vecs[i].b, {vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov});
            wait_result();
            collect();
        end

        // Random unsigned operands against the language's own / and %.
        sel8 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 5000);
            start_op(1'b0, ra, rb, {ra / rb, ra % rb, 2'b00});
            wait_result();
            collect();
        end

        // Back-pressure: result frozen while operands toggle, then back-to-back accept.
        start_op(1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFF2, 32'hFFFFFFFE, 2'b00});
        wait_result();
        e = exp_q[0];
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            drive_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (obs_res !== e || obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1) bad++;
        end
        check("bp_hold", bad, 0);
        e = exp_q.pop_front();
        @(negedge clk);
        drive_in(1'b1, 1'b0, 32'd12345, 32'd123);
        set_out_ready(1'b1);
        check("bp_result", obs_res, e);
        @(posedge clk);
        #1;
        set_out_ready(1'b0);
        check("b2b_ready_after_transfer", {obs_out_valid, obs_in_ready}, 2'b01);
        @(posedge clk);
        exp_q.push_back({32'd100, 32'd45, 2'b00});
        #1;
        drive_junk();
        check("b2b_accepted", obs_in_ready, 0);
        wait_result();
        collect();

        // Reset during CALC, ten iterations in.
        start_op(1'b0, 32'd999, 32'd3, {32'd333, 32'd0, 2'b00});
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_calc", {in_ready_32, out_valid_32, quotient_32, reminder_32, div_by_zero_32, overflow_32},
              {2'b10, 64'b0, 2'b00});
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_32 !== 1'b0) bad++;
        end
        check("no_stale_out_valid", bad, 0);
        start_op(1'b0, 32'd1000, 32'd10, {32'd100, 32'd0, 2'b00});
        wait_result();
        collect();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
